// File: rtl/hazard_stall_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : hazard_stall_ctrl                                          |
// | Description : Pipeline stall/flush sequencer: load-use bubbles, memory    |
// |               wait freeze, taken-branch flush, HLT drain and halt.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hazard_stall_ctrl #(
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_src,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_use_src,
    input  logic              id_use_dst,
    input  logic              id_hlt,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_mem_rd,
    input  logic              ex_wb,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int                  c_wait_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_timeout   = c_wait_w'(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);
    localparam logic [1:0]          c_drain_end = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_wait_w-1:0]  r_wait;
    logic [c_wait_w-1:0]  w_wait_nxt;
    logic [c_wait_w-1:0]  w_wait_inc;
    logic [1:0]           r_drain;
    logic [1:0]           w_drain_nxt;
    logic [1:0]           w_drain_inc;
    logic                 r_mem_err;
    logic                 w_mem_err_nxt;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic w_lu;
    logic w_mem_stall;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_ifid_flush;
    logic w_idex_flush;

    assign w_lu = ex_mem_rd & ex_wb &
                  ((id_use_src & (id_src == ex_dst)) | (id_use_dst & (id_dst == ex_dst)));
    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_wait_inc  = r_wait + c_wait_one;
    assign w_drain_inc = r_drain + 2'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_drain_nxt   = r_drain;
        w_mem_err_nxt = r_mem_err;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_wait_nxt = '0;
                if (w_mem_stall) begin
                    w_pc_en     = 1'b0;
                    w_ifid_en   = 1'b0;
                    w_idex_en   = 1'b0;
                    w_exmem_en  = 1'b0;
                    w_wait_nxt  = c_wait_one;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (ex_br_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_lu) begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                end else if (id_hlt) begin
                    w_pc_en      = 1'b0;
                    w_ifid_flush = 1'b1;
                    w_drain_nxt  = 2'd0;
                    w_state_nxt  = ST_DRAIN;
                end
            end

            // EX/ID are frozen here, so hazards are left for RUN to re-evaluate.
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc == c_timeout) begin
                        w_mem_err_nxt = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end
                end
            end

            // A memory wait while draining freezes everything and holds drain progress.
            ST_DRAIN: begin
                if (w_mem_stall) begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    w_wait_nxt = w_wait_inc;
                    if (w_wait_inc == c_timeout) begin
                        w_mem_err_nxt = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end
                end else begin
                    w_pc_en      = 1'b0;
                    w_ifid_flush = 1'b1;
                    w_wait_nxt   = '0;
                    w_drain_nxt  = w_drain_inc;
                    if (w_drain_inc == c_drain_end) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_idex_en  = 1'b0;
                w_exmem_en = 1'b0;
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait      <= '0;
            r_drain     <= 2'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_drain   <= w_drain_nxt;
            r_mem_err <= w_mem_err_nxt;
            if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Pipe runs freely with no flushes while reset is held.
    assign pc_en       = ~rst_n | w_pc_en;
    assign ifid_en     = ~rst_n | w_ifid_en;
    assign idex_en     = ~rst_n | w_idex_en;
    assign exmem_en    = ~rst_n | w_exmem_en;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_flush  = rst_n & w_idex_flush;
    assign stall_count = rst_n ? r_stall_cnt : '0;
    assign halted      = (r_state == ST_HALT);
    assign mem_err     = r_mem_err;

endmodule

`default_nettype wire
